// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
// One GROUP-bit lookahead group is evaluated per stage. Each stage registers its
// group carry-out, so no carry crosses a register boundary combinationally.
// The operand words travel down the pipeline with their transaction.
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / GROUP;

    // Index k is the input of stage k; index STAGES is the last stage's register.
    logic             v_w [STAGES+1];
    logic             c_w [STAGES+1];
    logic [WIDTH-1:0] s_w [STAGES+1];
    logic [WIDTH-1:0] a_w [STAGES];
    logic [WIDTH-1:0] b_w [STAGES];

    logic en;
    logic cm_q;

    // The whole pipeline moves as one unit: it advances unless a result is blocked.
    assign en       = !v_w[STAGES] || out_ready;
    assign in_ready = en && !rst;

    // B is inverted once at entry; the pipeline itself only ever adds.
    assign v_w[0] = in_valid;
    assign a_w[0] = a;
    assign b_w[0] = b ^ {WIDTH{sub}};
    assign c_w[0] = cin ^ sub;
    assign s_w[0] = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [GROUP-1:0] ga, gb, gp, gg, gs;
        logic [GROUP:0]   gc;
        logic [WIDTH-1:0] s_d, s_q;
        logic             v_q, c_q;

        assign ga = a_w[k][k*GROUP +: GROUP];
        assign gb = b_w[k][k*GROUP +: GROUP];

        // Lookahead: each carry is a flat sum of products of P/G and the group carry-in.
        always_comb begin
            logic prod;
            logic acc;
            gp    = ga ^ gb;
            gg    = ga & gb;
            gc    = '0;
            gc[0] = c_w[k];
            for (int i = 0; i < GROUP; i++) begin
                prod = c_w[k];
                for (int m = 0; m <= i; m++) prod = prod & gp[m];
                acc = prod;
                for (int j = 0; j <= i; j++) begin
                    prod = gg[j];
                    for (int m = j + 1; m <= i; m++) prod = prod & gp[m];
                    acc = acc | prod;
                end
                gc[i+1] = acc;
            end
            gs = gp ^ gc[GROUP-1:0];
        end

        // Merge this group's sum bits into the partial result carried from upstream.
        always_comb begin
            s_d = s_w[k];
            s_d[k*GROUP +: GROUP] = gs;
        end

        // Stage register: valid, partial sum and group carry-out.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= v_w[k];
                c_q <= gc[GROUP];
                s_q <= s_d;
            end
        end

        assign v_w[k+1] = v_q;
        assign c_w[k+1] = c_q;
        assign s_w[k+1] = s_q;

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] a_q, b_q;

            // Operands ride along so later groups see the bits of their own transaction.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_w[k];
                    b_q <= b_w[k];
                end
            end

            assign a_w[k+1] = a_q;
            assign b_w[k+1] = b_q;
        end else begin : g_last
            // Carry into the MSB, kept for the signed-overflow flag.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cm_q <= 1'b0;
                end else if (en) begin
                    cm_q <= gc[GROUP-1];
                end
            end
        end
    end

    assign out_valid = v_w[STAGES];
    assign sum       = s_w[STAGES];
    assign cout      = c_w[STAGES];
    assign ovf       = cm_q ^ c_w[STAGES];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed vectors on 16/4, a stalled stream, reset
// mid-flight, and random traffic on the 8/8 and 24/3 configurations.
module tb_cla_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        iv, ir, cin, sub, ov, ordy, co, of;
    logic [15:0] a, b, s;

    logic        iv8, ir8, cin8, sub8, ov8, or8, co8, of8;
    logic [7:0]  a8, b8, s8;

    logic        iv24, ir24, cin24, sub24, ov24, or24, co24, of24;
    logic [23:0] a24, b24, s24;

    int total = 0;
    int bad   = 0;

    cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov), .out_ready(ordy), .sum(s),
        .cout(co), .ovf(of)
    );

    cla_pipe_adder #(.WIDTH(8), .GROUP(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
        .cout(co8), .ovf(of8)
    );

    cla_pipe_adder #(.WIDTH(24), .GROUP(3)) dut24 (
        .clk(clk), .rst(rst), .in_valid(iv24), .in_ready(ir24), .a(a24), .b(b24),
        .cin(cin24), .sub(sub24), .out_valid(ov24), .out_ready(or24), .sum(s24),
        .cout(co24), .ovf(of24)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} for a w-bit add/subtract.
    function automatic logic [33:0] model(input int w, input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mc, input logic ms);
        logic [32:0] mask, be, full, rs;
        logic        rco, ro;
        mask = (33'd1 << w) - 33'd1;
        be   = ({1'b0, mb} ^ (ms ? mask : 33'd0)) & mask;
        full = ({1'b0, ma} & mask) + be + {32'd0, mc ^ ms};
        rs   = full & mask;
        rco  = full[w];
        ro   = (ma[w-1] == be[w-1]) && (rs[w-1] != ma[w-1]);
        return {ro, rco, rs[31:0]};
    endfunction

    task automatic run_vec(input string tag, input logic [15:0] va, input logic [15:0] vb,
                           input logic vc, input logic vs, input logic [15:0] es,
                           input logic ec, input logic eo);
        int cnt;
        @(negedge clk);
        a = va; b = vb; cin = vc; sub = vs; iv = 1'b1; ordy = 1'b1;
        #1;
        chk({tag, "_rdy"}, 64'(ir), 64'd1);
        @(negedge clk);
        iv = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        cnt = 1;
        while (!ov && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_lat"}, 64'(cnt), 64'd4);
        chk({tag, "_sum"}, 64'(s), 64'(es));
        chk({tag, "_cout"}, 64'(co), 64'(ec));
        chk({tag, "_ovf"}, 64'(of), 64'(eo));
    endtask

    task automatic rand_cfg(input int which, input int n);
        logic [33:0] q[$];
        logic [33:0] got;
        logic [31:0] ra, rb, mask;
        logic        rv, rr, rc, rs, gv, gr;
        int          w, sent, recv;
        w    = (which == 0) ? 8 : 24;
        mask = (32'd1 << w) - 32'd1;
        sent = 0;
        recv = 0;
        for (int c = 0; c < n * 8 + 100 && recv < n; c++) begin
            @(negedge clk);
            ra = $urandom & mask;
            rb = $urandom & mask;
            if ($urandom_range(0, 7) == 0) ra = mask;
            if ($urandom_range(0, 7) == 0) rb = 32'd1;
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            rv = (sent < n) && ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 3) != 0);
            if (which == 0) begin
                iv8 = rv; a8 = ra[7:0]; b8 = rb[7:0]; cin8 = rc; sub8 = rs; or8 = rr;
            end else begin
                iv24 = rv; a24 = ra[23:0]; b24 = rb[23:0]; cin24 = rc; sub24 = rs; or24 = rr;
            end
            #1;
            gv  = (which == 0) ? ov8 : ov24;
            gr  = (which == 0) ? ir8 : ir24;
            got = (which == 0) ? {of8, co8, 24'd0, s8} : {of24, co24, 8'd0, s24};
            if (gv && rr) begin
                if (q.size() == 0) chk("rnd_extra", 64'd1, 64'd0);
                else chk((which == 0) ? "rnd8_res" : "rnd24_res", 64'(got), 64'(q.pop_front()));
                recv++;
            end
            if (rv && gr) begin
                q.push_back(model(w, ra, rb, rc, rs));
                sent++;
            end
        end
        chk((which == 0) ? "rnd8_count" : "rnd24_count", 64'(recv), 64'(n));
        @(negedge clk);
        iv8 = 1'b0; iv24 = 1'b0;
    endtask

    initial begin
        logic [33:0] q[$];
        logic [15:0] sa [8];
        logic [15:0] sb [8];
        logic        sc [8];
        logic        ss [8];
        logic [17:0] held;
        logic        stall;
        int          sent, recv, seen;

        rst = 1'b1;
        iv = 0; a = '0; b = '0; cin = 0; sub = 0; ordy = 1;
        iv8 = 0; a8 = '0; b8 = '0; cin8 = 0; sub8 = 0; or8 = 1;
        iv24 = 0; a24 = '0; b24 = '0; cin24 = 0; sub24 = 0; or24 = 1;
        held = '0;

        @(negedge clk);
        iv = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_in_ready", 64'(ir), 64'd0);
        chk("rst_out_valid", 64'(ov), 64'd0);
        chk("rst_outs", 64'({s, co, of}), 64'd0);
        chk("rst_in_ready8_24", 64'({ir8, ir24}), 64'd0);
        iv = 1'b0;
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 64'(ir), 64'd1);

        run_vec("add_basic", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        run_vec("add_carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_vec("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_vec("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_vec("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_vec("sub_borrow",16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);
        run_vec("add_cin",   16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);

        // Stream of 8 with out_ready low for cycles 5..7.
        for (int i = 0; i < 8; i++) begin
            sa[i] = 16'($urandom);
            sb[i] = 16'($urandom);
            sc[i] = 1'($urandom_range(0, 1));
            ss[i] = 1'($urandom_range(0, 1));
        end
        sent = 0;
        recv = 0;
        for (int c = 0; c < 80 && recv < 8; c++) begin
            @(negedge clk);
            stall = (c >= 5 && c < 8);
            ordy  = !stall;
            if (sent < 8) begin
                iv = 1'b1; a = sa[sent]; b = sb[sent]; cin = sc[sent]; sub = ss[sent];
            end else begin
                iv = 1'b0;
            end
            #1;
            if (c < 12) chk("strm_in_ready", 64'(ir), 64'(!stall));
            if (c == 5) held = {of, co, s};
            if (c == 6 || c == 7) chk("strm_hold", 64'({ov, of, co, s}), 64'({1'b1, held}));
            if (ov && ordy) begin
                if (q.size() == 0) chk("strm_extra", 64'd1, 64'd0);
                else chk("strm_res", 64'({of, co, 16'd0, s}), 64'(q.pop_front()));
                recv++;
            end
            if (iv && ir) begin
                q.push_back(model(16, {16'd0, a}, {16'd0, b}, cin, sub));
                sent++;
            end
        end
        chk("strm_count", 64'(recv), 64'd8);
        @(negedge clk);
        iv = 1'b0;
        ordy = 1'b1;

        // Reset with three transactions in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            iv = 1'b1; a = 16'(16'h0100 * (i + 1)); b = 16'h0001; cin = 0; sub = 0;
        end
        @(negedge clk);
        iv = 1'b0;
        @(negedge clk);
        chk("rstm_pre_valid", 64'(ov), 64'd1);
        rst = 1'b1;
        #1;
        chk("rstm_valid_drop", 64'(ov), 64'd0);
        @(negedge clk);
        chk("rstm_in_ready", 64'(ir), 64'd0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ov) seen++;
        end
        chk("rstm_stale", 64'(seen), 64'd0);
        run_vec("rstm_new", 16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);

        rand_cfg(0, 300);
        rand_cfg(1, 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
